// File: rtl/imem_loader_if.sv
// imem_loader_if: word-in handshake plus byte-wide memory write port of the instruction loader
interface imem_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_word;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data;
  modport master (output in_valid, in_addr, in_word, input in_ready, mem_we, mem_addr, mem_data);
  modport slave (input in_valid, in_addr, in_word, output in_ready, mem_we, mem_addr, mem_data);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: serialises 32-bit instruction words into four big-endian byte writes
module imem_loader #(
  parameter int MEM_BYTES = 1000,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             err_clr,
  imem_loader_if.slave     bus,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] words_written
);
  localparam logic [31:0] LIM = 32'(MEM_BYTES - 4);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t      state;
  logic [1:0]  idx, nxt;
  logic [31:0] base, word, word_sh;
  logic        fire, in_range, legal, rej, last;
  always_comb begin
    fire     = bus.in_valid && bus.in_ready;
    in_range = bus.in_addr <= LIM;
    legal    = fire && in_range;
    rej      = fire && !in_range;
    last     = state == WRITE && idx == 2'd3;
    nxt      = idx + 2'd1;
    word_sh  = word << {nxt, 3'b000};
  end
  // outputs are registered alongside the state, so mem_we/busy track the beat being presented
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= 2'd0;
      base          <= '0;
      word          <= '0;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_data  <= '0;
      busy          <= 1'b0;
      err           <= 1'b0;
      words_written <= '0;
    end else begin
      err <= rej | (err & ~err_clr);
      if (last && ~&words_written) words_written <= words_written + 1'b1;
      if (legal) begin
        state        <= WRITE;
        idx          <= 2'd0;
        base         <= bus.in_addr;
        word         <= bus.in_word;
        bus.mem_we   <= 1'b1;
        bus.mem_addr <= bus.in_addr;
        bus.mem_data <= bus.in_word[31:24];
        bus.in_ready <= 1'b0;
        busy         <= 1'b1;
      end else if (state == WRITE && !last) begin
        idx          <= nxt;
        bus.mem_we   <= 1'b1;
        bus.mem_addr <= base + 32'(nxt);
        bus.mem_data <= word_sh[31:24];
        bus.in_ready <= nxt == 2'd3;
        busy         <= 1'b1;
      end else begin
        state        <= IDLE;
        bus.mem_we   <= 1'b0;
        bus.in_ready <= 1'b1;
        busy         <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table vectors, corner sequences and random traffic against a beat-queue model
module tb_imem_loader;
  logic clk = 0, rst = 1, err_clr = 0, err_clr2 = 0;
  logic busy, err, busy2, err2;
  logic [15:0] cnt;
  logic [1:0] cnt2;
  imem_loader_if v();
  imem_loader_if v2();
  imem_loader dut (.clk(clk), .rst(rst), .err_clr(err_clr), .bus(v), .busy(busy), .err(err), .words_written(cnt));
  imem_loader #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .err_clr(err_clr2), .bus(v2), .busy(busy2), .err(err2), .words_written(cnt2));
  always #5 clk = ~clk;

  typedef struct {logic [31:0] a; logic [7:0] d; bit l;} beat_t;
  typedef struct {logic [31:0] a; logic [31:0] w; bit ok;} vec_t;
  beat_t q[$];
  int checks = 0, passed = 0;
  bit m_ready = 0, m_err = 0, m_we = 0, m_last = 0, m_ad = 0, last_fire = 0;
  logic [31:0] m_addr = 0;
  logic [7:0]  m_data = 0;
  logic [15:0] m_cnt = 0;
  logic [7:0]  mem [0:1023];

  always @(posedge clk) if (v.mem_we) mem[v.mem_addr[9:0]] <= v.mem_data;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
  endtask

  function automatic logic [31:0] rd(logic [31:0] a);
    return {mem[a[9:0]], mem[a[9:0] + 10'd1], mem[a[9:0] + 10'd2], mem[a[9:0] + 10'd3]};
  endfunction

  // one clock: the model consumes the handshake seen at the edge, then every output is compared
  task automatic tick();
    bit fire, rej;
    beat_t b;
    fire = v.in_valid && m_ready && !rst;
    @(posedge clk);
    last_fire = fire;
    if (rst) begin
      q.delete();
      {m_ready, m_err, m_we, m_last, last_fire} = '0;
      m_ad = 1; m_addr = 0; m_data = 0; m_cnt = 0;
    end else begin
      if (m_last && m_cnt != 16'hFFFF) m_cnt++;
      rej = fire && v.in_addr > 32'd996;
      if (fire && !rej)
        for (int i = 0; i < 4; i++) q.push_back('{v.in_addr + i, v.in_word[31-8*i -: 8], i == 3});
      m_err = (m_err && !err_clr) || rej;
      m_we = 0; m_last = 0; m_ad = 0;
      if (q.size() > 0) begin
        b = q.pop_front();
        m_we = 1; m_ad = 1; m_addr = b.a; m_data = b.d; m_last = b.l;
      end
      m_ready = q.size() == 0;
    end
    #1;
    chk("mem_we", v.mem_we, m_we);
    chk("busy", busy, m_we);
    chk("in_ready", v.in_ready, m_ready);
    chk("err", err, m_err);
    chk("words_written", cnt, m_cnt);
    if (m_ad) begin
      chk("mem_addr", v.mem_addr, m_addr);
      chk("mem_data", v.mem_data, m_data);
    end
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic send(logic [31:0] a, logic [31:0] w);
    int n = 0;
    v.in_valid = 1; v.in_addr = a; v.in_word = w;
    do begin tick(); n++; end while (!last_fire && n < 20);
    chk("send_accept", last_fire, 1);
    v.in_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    logic [1:0] sat_exp[5];
    int k, ones, gaps, n;
    bit ended, acc;
    tbl = '{'{32'd0, 32'h8C220004, 1}, '{32'd996, 32'h11223344, 1}, '{32'd997, 32'h99999999, 0},
            '{32'hFFFFFFFF, 32'h77777777, 0}, '{32'd5, 32'hDEADBEEF, 1}};
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 1024; i++) mem[i] = 0;
    v.in_valid = 0; v.in_addr = 0; v.in_word = 0;
    v2.in_valid = 0; v2.in_addr = 0; v2.in_word = 0;
    rst = 1; idle(2); rst = 0; tick();

    foreach (tbl[i]) begin
      err_clr = 1; tick(); err_clr = 0;
      send(tbl[i].a, tbl[i].w);
      idle(5);
      chk("tbl_err", err, !tbl[i].ok);
      if (tbl[i].ok) chk("tbl_readback", rd(tbl[i].a), tbl[i].w);
    end

    k = 0; ones = 0; gaps = 0; ended = 0;
    v.in_valid = 1; v.in_addr = 0; v.in_word = 32'hA0000000;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (last_fire && k < 3) begin
        k++;
        if (k == 3) v.in_valid = 0;
        else begin v.in_addr = 4 * k; v.in_word = 32'hA0000000 | k; end
      end
      if (v.mem_we) begin ones++; if (ended) gaps++; end
      else if (ones > 0) ended = 1;
    end
    chk("b2b_beats", ones, 12);
    chk("b2b_gaps", gaps, 0);
    chk("b2b_readback", rd(32'd8), 32'hA0000002);

    send(32'd997, 32'h1);
    err_clr = 1; send(32'hFFFFFFFF, 32'h2); err_clr = 0;
    tick();
    chk("err_set_clr_same", err, 1);
    err_clr = 1; tick(); err_clr = 0; tick();
    chk("err_cleared", err, 0);

    rst = 1; tick(); rst = 0; tick();
    send(32'd20, 32'h55667788);
    tick();
    rst = 1; tick();
    chk("rst_mem_we", v.mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", cnt, 0);
    rst = 0; tick();
    chk("rst_ready", v.in_ready, 1);
    send(32'd40, 32'hCAFEF00D);
    idle(5);
    chk("rst_new_word", rd(32'd40), 32'hCAFEF00D);
    chk("rst_partial", {mem[20], mem[21], mem[22]}, 24'h556600);
    chk("rst_cnt_after", cnt, 1);

    for (int i = 0; i < 400; i++) begin
      if (!v.in_valid || last_fire) begin
        v.in_valid = $urandom_range(0, 3) != 0;
        k = $urandom_range(0, 3);
        v.in_addr = k == 0 ? $urandom_range(990, 1000) : k == 1 ? $urandom : $urandom_range(0, 996);
        v.in_word = $urandom;
      end
      err_clr = $urandom_range(0, 7) == 0;
      tick();
    end
    v.in_valid = 0; err_clr = 0;
    idle(6);

    for (int j = 0; j < 5; j++) begin
      v2.in_valid = 1; v2.in_addr = 4 * j; v2.in_word = $urandom;
      n = 0;
      do begin acc = v2.in_ready; @(posedge clk); #1; n++; end while (!acc && n < 10);
      v2.in_valid = 0;
      chk("sat_accept", acc, 1);
      repeat (6) @(posedge clk);
      #1;
      chk("sat_cnt", cnt2, sat_exp[j]);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
